// File: rtl/alu_issue.sv
// alu_issue: single-issue sequencer in front of a registered 16-bit ALU.
// Owns the register file, reads the operands, hands ctrl/a/b to the ALU,
// and writes the ALU result back two cycles after the instruction is accepted.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | ready for an instruction; ALU inputs hold their last values
// S_EXEC | ALU samples ctrl/a/b on the edge that leaves this state
// S_WB   | alu_y is valid; it is strobed out and committed to rd
module alu_issue #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       instr_valid,
   output logic                       instr_ready,
   input  logic [3:0]                 instr_op,
   input  logic [$clog2(NREGS)-1:0]   instr_rd,
   input  logic [$clog2(NREGS)-1:0]   instr_rs,
   input  logic [$clog2(NREGS)-1:0]   instr_rt,
   input  logic                       instr_imm,
   output logic [3:0]                 alu_ctrl,
   output logic [DATA_W-1:0]          alu_a,
   output logic [DATA_W-1:0]          alu_b,
   input  logic [DATA_W-1:0]          alu_y,
   output logic                       wb_valid,
   output logic [$clog2(NREGS)-1:0]   wb_addr,
   output logic [DATA_W-1:0]          wb_data,
   output logic                       busy,
   input  logic [$clog2(NREGS)-1:0]   dbg_addr,
   output logic [DATA_W-1:0]          dbg_data
);

   localparam int AW = $clog2(NREGS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [DATA_W-1:0]   r_regs [NREGS];
   logic [3:0]          r_ctrl;
   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;
   logic [AW-1:0]       r_rd;
   logic                w_accept;
   logic [DATA_W-1:0]   w_rs_val;
   logic [DATA_W-1:0]   w_rt_val;

   // r0 reads as zero regardless of storage contents
   assign w_rs_val = (instr_rs == '0) ? '0 : r_regs[instr_rs];
   assign w_rt_val = (instr_rt == '0) ? '0 : r_regs[instr_rt];
   assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];
   assign w_accept = instr_valid & instr_ready;

   assign alu_ctrl = r_ctrl;
   assign alu_a    = r_a;
   assign alu_b    = r_b;
   assign wb_addr  = r_rd;
   assign wb_data  = alu_y;
   assign busy     = (r_state != S_IDLE);

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // next-state and handshake/strobe outputs
   always_comb begin
      w_next      = r_state;
      instr_ready = 1'b0;
      wb_valid    = 1'b0;
      case (r_state)
         S_IDLE: begin
            // held low while reset is asserted so nothing is offered mid-reset
            instr_ready = ~reset;
            if (instr_valid && !reset) w_next = S_EXEC;
         end
         S_EXEC: w_next = S_WB;
         S_WB: begin
            wb_valid = 1'b1;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // operand/ctrl capture at accept; values hold until the next accept
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ctrl <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_rd   <= '0;
      end else if (w_accept) begin
         r_ctrl <= instr_op;
         r_a    <= w_rs_val;
         r_b    <= instr_imm ? {{(DATA_W-AW){1'b0}}, instr_rt} : w_rt_val;
         r_rd   <= instr_rd;
      end
   end

   // register file write-back; writes to r0 are dropped
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else if (r_state == S_WB && r_rd != '0) begin
         r_regs[r_rd] <= alu_y;
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small registered ALU model attached.
module tb_alu_issue;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_NOR = 4'd3;
   localparam logic [3:0] OP_SWP = 4'd4;
   localparam logic [3:0] OP_BAD = 4'd15;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [3:0]  instr_op;
   logic [3:0]  instr_rd;
   logic [3:0]  instr_rs;
   logic [3:0]  instr_rt;
   logic        instr_imm;
   logic [3:0]  alu_ctrl;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_y = 16'h0;
   logic        wb_valid;
   logic [3:0]  wb_addr;
   logic [15:0] wb_data;
   logic        busy;
   logic [3:0]  dbg_addr;
   logic [15:0] dbg_data;

   int n_chk = 0;
   int n_err = 0;
   logic [15:0] mregs [16];

   alu_issue #(.DATA_W(16), .NREGS(16)) dut (
      .clk(clk), .reset(reset),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
      .instr_rt(instr_rt), .instr_imm(instr_imm),
      .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] alu_f(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] p;
      p = a * b;
      case (c)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_MUL:  return p[15:0];
         OP_NOR:  return ~(a | b);
         OP_SWP:  return {a[7:0], a[15:8]};
         default: return 16'h0;
      endcase
   endfunction

   // registered ALU: one-cycle latency from ctrl/a/b to y
   always @(posedge clk) alu_y <= alu_f(alu_ctrl, alu_a, alu_b);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   // one full instruction, checking the accept/exec/writeback timeline
   task automatic do_op(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [3:0] rt, input logic imm, input logic [15:0] exp,
                        input logic scramble);
      logic [15:0] exp_reg;
      @(negedge clk);
      instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt; instr_imm = imm;
      instr_valid = 1'b1; dbg_addr = rd;
      chk("ready_idle", instr_ready, 1);
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      chk("exec_busy", busy, 1);
      chk("exec_ready", instr_ready, 0);
      chk("exec_wbv", wb_valid, 0);
      chk("exec_ctrl", alu_ctrl, op);
      if (scramble) begin
         instr_op = OP_BAD; instr_rs = ~rs; instr_rt = ~rt; instr_imm = ~imm; instr_rd = ~rd;
      end
      @(negedge clk);
      chk("wb_valid", wb_valid, 1);
      chk("wb_addr", wb_addr, rd);
      chk("wb_data", wb_data, exp);
      chk("wb_ready", instr_ready, 0);
      chk("wb_dbg_old", dbg_data, mregs[rd]);
      @(negedge clk);
      exp_reg = (rd == 4'd0) ? 16'h0 : exp;
      if (rd != 4'd0) mregs[rd] = exp;
      chk("post_wbv", wb_valid, 0);
      chk("post_ready", instr_ready, 1);
      chk("post_busy", busy, 0);
      chk("post_dbg", dbg_data, exp_reg);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      int acc;
      int nwb;
      int cyc;
      int acc_cyc [4];
      logic seen;

      for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
      reset = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0;
      instr_rs = '0; instr_rt = '0; instr_imm = 1'b0; dbg_addr = 4'd1;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_wbv", wb_valid, 0);
      reset = 1'b0;
      #1;
      chk("rst_ready", instr_ready, 1);
      chk("rst_ctrl", alu_ctrl, 0);
      chk("rst_a", alu_a, 0);
      chk("rst_b", alu_b, 0);
      chk("rst_r1", dbg_data, 0);

      // immediate add and register ops
      do_op(OP_ADD, 4'd1, 4'd0, 4'd5, 1'b1, 16'h0005, 1'b0);
      chk("hold_ctrl", alu_ctrl, OP_ADD);
      chk("hold_b", alu_b, 16'h0005);
      do_op(OP_ADD, 4'd2, 4'd0, 4'd3, 1'b1, 16'h0003, 1'b0);
      do_op(OP_SUB, 4'd3, 4'd1, 4'd2, 1'b0, 16'h0002, 1'b0);
      do_op(OP_MUL, 4'd4, 4'd1, 4'd1, 1'b0, 16'h0019, 1'b0);
      do_op(OP_NOR, 4'd5, 4'd0, 4'd0, 1'b0, 16'hFFFF, 1'b0);
      do_op(OP_SWP, 4'd6, 4'd5, 4'd0, 1'b0, 16'hFFFF, 1'b0);
      // rd == rs uses old value: r3 = r3 + r3 = 4
      do_op(OP_ADD, 4'd3, 4'd3, 4'd3, 1'b0, 16'h0004, 1'b0);
      do_op(OP_BAD, 4'd7, 4'd2, 4'd3, 1'b0, 16'h0000, 1'b0);

      // back-to-back: clear r1, then four r1 += 1 with valid held high
      do_op(OP_ADD, 4'd1, 4'd0, 4'd0, 1'b1, 16'h0000, 1'b0);
      @(negedge clk);
      instr_op = OP_ADD; instr_rd = 4'd1; instr_rs = 4'd1; instr_rt = 4'd1;
      instr_imm = 1'b1; instr_valid = 1'b1; dbg_addr = 4'd1;
      acc = 0; nwb = 0; cyc = 0;
      for (int k = 0; k < 30; k++) begin
         if (wb_valid) begin
            nwb++;
            chk("b2b_wb_data", wb_data, nwb);
         end
         if (instr_ready) begin
            if (acc == 4) begin
               instr_valid = 1'b0;
               break;
            end
            acc_cyc[acc] = cyc;
            acc++;
         end
         @(negedge clk);
         cyc++;
      end
      instr_valid = 1'b0;
      chk("b2b_accepts", acc, 4);
      chk("b2b_wbs", nwb, 4);
      chk("b2b_gap01", acc_cyc[1] - acc_cyc[0], 3);
      chk("b2b_gap23", acc_cyc[3] - acc_cyc[2], 3);
      chk("b2b_r1", dbg_data, 16'h0004);
      mregs[1] = 16'h0004;

      // r0 write dropped but strobed
      do_op(OP_ADD, 4'd0, 4'd0, 4'd7, 1'b1, 16'h0007, 1'b0);
      do_op(OP_ADD, 4'd1, 4'd0, 4'd0, 1'b1, 16'h0000, 1'b0);

      // reset during EXEC aborts the writeback
      do_op(OP_ADD, 4'd1, 4'd0, 4'd9, 1'b1, 16'h0009, 1'b0);
      @(negedge clk);
      instr_op = OP_ADD; instr_rd = 4'd1; instr_rs = 4'd1; instr_rt = 4'd1;
      instr_imm = 1'b1; instr_valid = 1'b1; dbg_addr = 4'd1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      chk("mid_busy", busy, 1);
      reset = 1'b1;
      #1;
      seen = wb_valid;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_r1", dbg_data, 0);
      repeat (2) begin
         @(negedge clk);
         if (wb_valid) seen = 1'b1;
      end
      reset = 1'b0;
      #1;
      chk("mid_rel_ready", instr_ready, 1);
      chk("mid_rel_busy", busy, 0);
      repeat (3) begin
         @(negedge clk);
         if (wb_valid) seen = 1'b1;
      end
      chk("mid_no_wb", seen, 0);
      chk("mid_r1_after", dbg_data, 0);
      for (int i = 0; i < 16; i++) mregs[i] = 16'h0;

      // fields changed during EXEC must not matter
      do_op(OP_ADD, 4'd2, 4'd0, 4'd10, 1'b1, 16'h000A, 1'b0);
      do_op(OP_ADD, 4'd3, 4'd0, 4'd3, 1'b1, 16'h0003, 1'b0);
      do_op(OP_SUB, 4'd4, 4'd2, 4'd3, 1'b0, 16'h0007, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
